// File: rtl/mul_tree_collector.sv
// Collects per-lane bf16 results from mul_tree_bf16 into packed groups and
// streams them out of a show-ahead FIFO with a wrapping sequence tag.
module mul_tree_collector #(
  parameter int unsigned DW       = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*DW-1:0]          lane_data,
  input  logic [3:0]               lane_stb,
  input  logic [1:0]               mode,
  output logic [4*DW-1:0]          out_data,
  output logic [3:0]               out_mask,
  output logic [3:0]               out_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     err_overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 4 * DW + 8;

  logic [DW-1:0]   hold [4];
  logic [3:0]      cap;
  logic [3:0]      grp_mask;
  logic [3:0]      tag_ctr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [EW-1:0]   mem [DEPTH];

  logic [3:0]      mode_mask;
  logic            grp_done;
  logic            pop;
  logic            push;
  logic [3:0]      cap_base;
  logic [3:0]      eff_mask;
  logic [3:0]      take;
  logic            overrun;
  logic [3:0]      cap_nxt;
  logic [4*DW-1:0] push_data;
  logic [EW-1:0]   push_entry;
  logic [AW-1:0]   wr_nxt;
  logic [AW-1:0]   rd_nxt;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   remain;
  logic            valid_nxt;
  logic [EW-1:0]   head_nxt;

  // Group assembly, push/pop decisions and next head of the FIFO
  always_comb begin
    mode_mask  = 4'b1111;
    push_data  = '0;
    head_nxt   = {out_tag, out_mask, out_data};
    valid_nxt  = 1'b0;

    case (mode)
      2'b00:   mode_mask = 4'b1111;
      2'b01:   mode_mask = 4'b0011;
      default: mode_mask = 4'b0001;
    endcase

    grp_done = ((cap & grp_mask) == grp_mask);
    pop      = out_valid & out_ready;
    push     = grp_done & ((count != CW'(DEPTH)) | pop);

    // A push frees the capture flags this cycle, so same-cycle strobes open the next group
    cap_base = push ? 4'b0000 : cap;
    eff_mask = (cap_base == 4'b0000) ? mode_mask : grp_mask;
    take     = lane_stb & eff_mask & ~cap_base;
    overrun  = |(lane_stb & eff_mask & cap_base);
    cap_nxt  = cap_base | take;

    for (int i = 0; i < 4; i++) begin
      if (grp_mask[i]) push_data[i*DW +: DW] = hold[i];
    end
    push_entry = {tag_ctr, grp_mask, push_data};

    wr_nxt    = wr_ptr + AW'(push);
    rd_nxt    = rd_ptr + AW'(pop);
    count_nxt = count + CW'(push) - CW'(pop);
    remain    = count - CW'(pop);

    // Entries already resident take priority; an empty FIFO shows the incoming push
    if (remain != '0) begin
      valid_nxt = 1'b1;
      head_nxt  = mem[rd_nxt];
    end else if (push) begin
      valid_nxt = 1'b1;
      head_nxt  = push_entry;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap         <= 4'b0000;
      grp_mask    <= 4'b1111;
      tag_ctr     <= 4'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      err_overrun <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_mask    <= 4'b0000;
      out_tag     <= 4'd0;
    end else begin
      cap         <= cap_nxt;
      grp_mask    <= eff_mask;
      tag_ctr     <= tag_ctr + 4'(push);
      wr_ptr      <= wr_nxt;
      rd_ptr      <= rd_nxt;
      count       <= count_nxt;
      almost_full <= (count_nxt >= CW'(AF_LEVEL));
      err_overrun <= err_overrun | overrun;
      out_valid   <= valid_nxt;
      out_tag     <= head_nxt[EW-1 -: 4];
      out_mask    <= head_nxt[EW-5 -: 4];
      out_data    <= head_nxt[4*DW-1:0];
    end
  end

  // Storage arrays carry no reset; pointers and flags define what is live
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= push_entry;
    for (int i = 0; i < 4; i++) begin
      if (rst && take[i]) hold[i] <= lane_data[i*DW +: DW];
    end
  end

endmodule

// File: doc/mul_tree_collector.md
# mul_tree_collector

Downstream stage of `mul_tree_bf16`. Captures the per-lane bf16 results and per-lane strobes, which may arrive in different cycles, and assembles each lane group selected by `mode` into one packed word. Completed groups go into a show-ahead FIFO and leave on a valid/ready stream with a wrapping sequence tag. It also reports FIFO occupancy and overrun conditions, because the tree upstream has no backpressure.

## Interface

Parameters:
- `DW`, 16, width of one lane result (bf16).
- `DEPTH`, 8, FIFO entries; a power of two, at least 2.
- `AF_LEVEL`, 6, occupancy at or above which `almost_full` asserts.

Ports:
- `clk`, in, 1, the single clock; all logic is on the rising edge.
- `rst`, in, 1, reset. Synchronous, active-low: `rst`=0 at a rising edge resets the block.
- `lane_data`, in, 4*DW, lane i result at bits [i*DW +: DW]; connects to `outputs` of `mul_tree_bf16`.
- `lane_stb`, in, 4, per-lane valid, one-cycle pulses; connects to `final_output_stbs_1`.
- `mode`, in, 2, the same mode driven into the tree; selects the active-lane mask.
- `out_data`, out, 4*DW, packed group; inactive lanes are zero.
- `out_mask`, out, 4, active-lane mask of the group.
- `out_tag`, out, 4, group sequence number.
- `out_valid`, out, 1, the FIFO head is valid.
- `out_ready`, in, 1, consumer accepts the head.
- `count`, out, $clog2(DEPTH)+1, FIFO occupancy.
- `almost_full`, out, 1, `count` >= `AF_LEVEL`.
- `err_overrun`, out, 1, sticky error flag.

## Operation

Mode-to-mask mapping:
- `mode` 00 gives mask 1111.
- `mode` 01 gives mask 0011.
- `mode` 10 gives mask 0001.
- `mode` 11 gives mask 0001.

Mask latching:
- `mode` is latched into `grp_mask` only while no capture flag is set.
- After the first capture of a group, changes on `mode` are ignored until that group is pushed.

Capture stage:
- There are 4 holding registers plus flags `cap[3:0]`.
- A strobe on active lane i with `cap[i]`=0 stores `lane_data` lane i and sets `cap[i]`.
- A strobe on an inactive lane is ignored and does not set the error.
- A strobe on lane i while `cap[i]`=1 and the group is not being pushed that cycle: the new data is dropped and `err_overrun` is set.

Push:
- Condition: (`cap` & `grp_mask`) == `grp_mask` and (FIFO not full, or a pop occurs in the same cycle).
- On push, write {data, mask, tag} to the FIFO, clear `cap`, and increment `tag_ctr`.
- `tag_ctr` is 4 bits and wraps 15 -> 0.
- If the group is complete but the FIFO is full with no pop, the group holds in the capture registers. Any strobe to a held lane sets `err_overrun`.
- A strobe on lane i in the same cycle that the group is pushed is captured into the new group; set wins over clear.

FIFO:
- Circular buffer of `DEPTH` entries; pointers wrap modulo `DEPTH`.
- Pop occurs when `out_valid` && `out_ready`.
- Simultaneous push and pop leaves `count` unchanged, including when full.
- Pop when empty is impossible because `out_valid`=0.

`err_overrun` is cleared only by reset.

Reset (`rst`=0):
- Outputs: `out_valid`=0, `count`=0, `almost_full`=0, `err_overrun`=0, `out_tag`=0, `out_data`=0, `out_mask`=0.
- Internal state: `cap`=0, `tag_ctr`=0, `grp_mask`=1111.
- The FIFO contents are discarded.
- A reset in the middle of a group or with entries in the FIFO drops everything. The first group after reset carries tag 0.

## Timing

- Lane strobe seen at rising edge E sets `cap` at E.
- The push is evaluated on the registered `cap` and happens at E+1.
- `out_valid`, `out_data`, `out_mask` and `out_tag` are registered and reflect the new head after E+1. Latency from the last required strobe to `out_valid` is therefore 2 cycles.
- Sustained throughput is one group per cycle.
- `out_data`, `out_mask` and `out_tag` are stable while `out_valid`=1 and `out_ready`=0.
- `count` and `almost_full` are registered and update at the push or pop edge.

## Test plan

- **Mode 00, aligned strobes.** Reset; then `lane_stb`=1111 for one cycle with lanes 0x3F80, 0x4000, 0x4040, 0x4080, `out_ready`=1.
  - `out_valid` goes high 2 cycles later with `out_data`={0x4080,0x4040,0x4000,0x3F80}, `out_mask`=1111, `out_tag`=0.
- **Mode 00, skewed strobes.** Lanes strobe individually on cycles 0, 1, 3 and 4.
  - Exactly one group is pushed, with `out_valid` high at cycle 6.
  - No output appears earlier.
- **Mode 10.** Strobes on lanes 0 and 2 in the same cycle, lane 0 = 0x3F80.
  - `out_data` lane 0 = 0x3F80, all other lanes 0, `out_mask`=0001.
  - `err_overrun` stays 0.
- **Backpressure and overrun.** `out_ready`=0; push 8 groups in mode 11.
  - `almost_full` asserts when `count` reaches 6, and `count` reaches 8.
  - A 9th group holds in capture; a 10th lane-0 strobe sets `err_overrun`.
  - Raising `out_ready` drains tags 0..7, then the held group as tag 8.
- **Tag wrap and simultaneous push/pop.** 20 back-to-back groups with `out_ready`=1.
  - Tags run 0..15 then 0..3.
  - `count` never exceeds 1; no errors.
- **Reset mid-operation.** Drive `rst`=0 with 3 FIFO entries and `cap`=0101.
  - The next cycle shows `count`=0 and `out_valid`=0.
  - The next group comes out with tag 0.
